uart_busmaster: RTL and testbench

UART_BUSMASTER -- requirements
Module: uart_busmaster

---
 rtl/uart_busmaster.sv | 196 +++++++++++++++++++
 tb/tb_uart_busmaster.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_busmaster.sv
// UART-driven bus master: 'R'/'W' command frames become single bus cycles.
// Define BM_ACKTO_EN to abort a stalled request/cycle after ACK_TIMEOUT clocks.
module uart_busmaster #(
    parameter int CLK_HZ      = 24000000,
    parameter int BAUD        = 115200,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk_in,
    input  logic        b_reset,
    input  logic        rxd,
    output logic        txd,
    output logic        bm_req,
    input  logic        bm_gnt,
    output logic        bm_cyc,
    output logic [15:0] bm_ad,
    output logic        bm_rw,
    output logic [7:0]  bm_do,
    input  logic [7:0]  bm_di,
    input  logic        bm_ack
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = $clog2(DIV + 1);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR_H, S_ADDR_L, S_DATA, S_REQ, S_CYC, S_REPLY
    } state_t;

    logic          r_rx_s1, r_rx_s2, r_rx_s3;
    logic          r_rx_act, r_rx_vld;
    logic [CW-1:0] r_rx_cnt;
    logic [3:0]    r_rx_idx;
    logic [7:0]    r_rx_sh;
    logic          w_rx_fall;

    logic          r_tx_busy;
    logic [9:0]    r_tx_sh;
    logic [CW-1:0] r_tx_cnt;
    logic [3:0]    r_tx_idx;
    logic          w_tx_load;
    logic [7:0]    w_tx_data;

    state_t        r_st, w_nx;
    logic          r_rd;
    logic [15:0]   r_ad;
    logic [7:0]    r_do, r_reply;
    logic          w_is_op, w_to;

    assign w_rx_fall = r_rx_s3 & ~r_rx_s2;

    // idx 0 = start-bit recheck, 1..8 = data, 9 = stop
    always_ff @(posedge clk_in or negedge b_reset) begin
        if (!b_reset) begin
            r_rx_s1  <= 1'b1;
            r_rx_s2  <= 1'b1;
            r_rx_s3  <= 1'b1;
            r_rx_act <= 1'b0;
            r_rx_vld <= 1'b0;
            r_rx_cnt <= '0;
            r_rx_idx <= '0;
            r_rx_sh  <= '0;
        end else begin
            r_rx_s1  <= rxd;
            r_rx_s2  <= r_rx_s1;
            r_rx_s3  <= r_rx_s2;
            r_rx_vld <= 1'b0;
            if (!r_rx_act) begin
                if (w_rx_fall) begin
                    r_rx_act <= 1'b1;
                    r_rx_cnt <= '0;
                    r_rx_idx <= '0;
                end
            end else if (r_rx_idx == 4'd0) begin
                if (r_rx_cnt == HALF_M1) begin
                    r_rx_cnt <= '0;
                    if (r_rx_s2) r_rx_act <= 1'b0;
                    else         r_rx_idx <= 4'd1;
                end else begin
                    r_rx_cnt <= r_rx_cnt + 1'b1;
                end
            end else if (r_rx_cnt == DIV_M1) begin
                r_rx_cnt <= '0;
                if (r_rx_idx == 4'd9) begin
                    r_rx_act <= 1'b0;
                    r_rx_vld <= r_rx_s2;
                end else begin
                    r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
                    r_rx_idx <= r_rx_idx + 1'b1;
                end
            end else begin
                r_rx_cnt <= r_rx_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge b_reset) begin
        if (!b_reset) begin
            r_tx_busy <= 1'b0;
            r_tx_sh   <= '1;
            r_tx_cnt  <= '0;
            r_tx_idx  <= '0;
        end else if (w_tx_load) begin
            r_tx_busy <= 1'b1;
            r_tx_sh   <= {1'b1, w_tx_data, 1'b0};
            r_tx_cnt  <= '0;
            r_tx_idx  <= '0;
        end else if (r_tx_busy) begin
            if (r_tx_cnt == DIV_M1) begin
                r_tx_cnt <= '0;
                r_tx_sh  <= {1'b1, r_tx_sh[9:1]};
                if (r_tx_idx == 4'd9) r_tx_busy <= 1'b0;
                else                  r_tx_idx  <= r_tx_idx + 1'b1;
            end else begin
                r_tx_cnt <= r_tx_cnt + 1'b1;
            end
        end
    end

    assign txd = r_tx_busy ? r_tx_sh[0] : 1'b1;

`ifdef BM_ACKTO_EN
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    logic [TW-1:0] r_to;

    always_ff @(posedge clk_in or negedge b_reset) begin
        if (!b_reset)
            r_to <= '0;
        else if (r_st == S_REQ || r_st == S_CYC)
            r_to <= r_to + 1'b1;
        else
            r_to <= '0;
    end

    assign w_to = (r_to == TW'(ACK_TIMEOUT - 1));
`else
    assign w_to = 1'b0;
`endif

    assign w_is_op = (r_rx_sh == 8'h52) || (r_rx_sh == 8'h57);

    always_comb begin
        w_nx      = r_st;
        w_tx_load = 1'b0;
        w_tx_data = r_reply;
        unique case (r_st)
            S_IDLE:   if (r_rx_vld) w_nx = w_is_op ? S_ADDR_H : S_REPLY;
            S_ADDR_H: if (r_rx_vld) w_nx = S_ADDR_L;
            S_ADDR_L: if (r_rx_vld) w_nx = r_rd ? S_REQ : S_DATA;
            S_DATA:   if (r_rx_vld) w_nx = S_REQ;
            S_REQ: begin
                if (w_to)        w_nx = S_REPLY;
                else if (bm_gnt) w_nx = S_CYC;
            end
            S_CYC:    if (bm_ack || w_to) w_nx = S_REPLY;
            S_REPLY: begin
                if (!r_tx_busy) begin
                    w_tx_load = 1'b1;
                    w_nx      = S_IDLE;
                end
            end
            default:  w_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge b_reset) begin
        if (!b_reset) begin
            r_st    <= S_IDLE;
            r_rd    <= 1'b1;
            r_ad    <= '0;
            r_do    <= '0;
            r_reply <= '0;
        end else begin
            r_st <= w_nx;
            if (r_st == S_IDLE && r_rx_vld) begin
                if (w_is_op) r_rd    <= (r_rx_sh == 8'h52);
                else         r_reply <= 8'h3F;
            end
            if (r_st == S_ADDR_H && r_rx_vld) r_ad[15:8] <= r_rx_sh;
            if (r_st == S_ADDR_L && r_rx_vld) r_ad[7:0]  <= r_rx_sh;
            if (r_st == S_DATA && r_rx_vld)   r_do       <= r_rx_sh;
            // ack wins over a timeout landing on the same edge
            if (r_st == S_CYC && bm_ack)
                r_reply <= r_rd ? bm_di : 8'h2E;
            else if ((r_st == S_REQ || r_st == S_CYC) && w_to)
                r_reply <= 8'h21;
        end
    end

    assign bm_req = (r_st == S_REQ) || (r_st == S_CYC);
    assign bm_cyc = (r_st == S_CYC);
    assign bm_rw  = r_rd;
    assign bm_ad  = r_ad;
    assign bm_do  = r_do;

endmodule

// File: tb/tb_uart_busmaster.sv
// Randomized self-checking bench for uart_busmaster with a frame-level
// reference model, a bus-slave agent and a serial reply decoder.
module tb_uart_busmaster;
    localparam int DIV = 16;
    localparam int TO  = 40;

    logic        clk_in = 1'b0;
    logic        b_reset = 1'b0;
    logic        rxd = 1'b1;
    logic        txd, bm_req, bm_gnt, bm_cyc, bm_rw, bm_ack;
    logic [15:0] bm_ad;
    logic [7:0]  bm_do, bm_di;

    uart_busmaster #(
        .CLK_HZ(1600000), .BAUD(100000), .ACK_TIMEOUT(TO)
    ) dut (
        .clk_in(clk_in), .b_reset(b_reset), .rxd(rxd), .txd(txd),
        .bm_req(bm_req), .bm_gnt(bm_gnt), .bm_cyc(bm_cyc),
        .bm_ad(bm_ad), .bm_rw(bm_rw), .bm_do(bm_do),
        .bm_di(bm_di), .bm_ack(bm_ack)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [15:0] ad;
        logic        rw;
        logic [7:0]  dout;
    } bus_t;

    int vectors = 0;
    int errs = 0;

    bit   gnt_en = 1, ack_en = 1, gnt_drop = 0;
    int   ack_dly = 3;
    int   cyc_n = 0;
    logic [7:0] rd_data = 8'h00;
    logic [7:0] m_do = 8'h00;

    bus_t bus_q[$];
    logic [7:0] tx_q[$];
    bus_t mon_cur;
    logic mon_pc = 1'b0, mon_pr = 1'b0;
    int   stab_err = 0, req_run = 0, req_len = 0;
    logic [7:0] tx_b;

    // bus slave: grants while requested, acks ack_dly cycles into the cycle
    initial begin
        bm_gnt = 1'b0;
        bm_ack = 1'b0;
        bm_di  = 8'h00;
        forever begin
            @(negedge clk_in);
            bm_ack = 1'b0;
            bm_di  = 8'($urandom);
            if (!b_reset || !bm_req) begin
                bm_gnt = 1'b0;
                cyc_n  = 0;
            end else begin
                bm_gnt = gnt_en;
                if (bm_cyc) begin
                    cyc_n++;
                    if (gnt_drop) bm_gnt = 1'b0;
                    if (ack_en && cyc_n == ack_dly) begin
                        bm_ack = 1'b1;
                        bm_di  = rd_data;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_in);
            if (bm_cyc && !mon_pc) begin
                mon_cur = {bm_ad, bm_rw, bm_do};
                bus_q.push_back(mon_cur);
            end else if (bm_cyc && mon_cur != {bm_ad, bm_rw, bm_do}) begin
                stab_err++;
            end
            if (bm_req) req_run = mon_pr ? req_run + 1 : 1;
            else if (mon_pr) req_len = req_run;
            mon_pc = bm_cyc;
            mon_pr = bm_req;
        end
    end

    initial begin
        forever begin
            @(negedge clk_in);
            if (b_reset && txd === 1'b0) begin
                repeat (DIV / 2) @(negedge clk_in);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk_in);
                    tx_b[i] = txd;
                end
                repeat (DIV) @(negedge clk_in);
                vectors++;
                if (txd !== 1'b1) begin
                    errs++;
                    $display("FAIL tx_stop: got %b want 1", txd);
                end
                tx_q.push_back(tx_b);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (DIV) @(negedge clk_in);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (DIV) @(negedge clk_in);
        end
        rxd = stop;
        repeat (DIV) @(negedge clk_in);
        rxd = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [15:0] a,
                              input logic [7:0] d);
        send_byte(op, 1'b1);
        if (op == 8'h52 || op == 8'h57) begin
            send_byte(a[15:8], 1'b1);
            send_byte(a[7:0], 1'b1);
            if (op == 8'h57) send_byte(d, 1'b1);
        end
    endtask

    task automatic get_reply(output logic [7:0] r);
        r = 'x;
        for (int i = 0; i < 4000 && tx_q.size() == 0; i++)
            @(negedge clk_in);
        if (tx_q.size() > 0) r = tx_q.pop_front();
    endtask

    // reference: what the frame should do on the bus and what it answers
    function automatic void ref_frame(input logic [7:0] op,
                                      input logic [15:0] a,
                                      input logic [7:0] d,
                                      input logic [7:0] rdv,
                                      output bit is_bus, output bus_t eb,
                                      output logic [7:0] rep);
        is_bus = (op == 8'h52) || (op == 8'h57);
        if (op == 8'h57) m_do = d;
        eb  = {a, op == 8'h52, m_do};
        rep = !is_bus ? 8'h3F : (op == 8'h52) ? rdv : 8'h2E;
    endfunction

    task automatic test_reset();
        b_reset = 1'b0;
        repeat (3) @(negedge clk_in);
        vectors += 6;
        if (txd !== 1'b1) begin errs++; $display("FAIL rst_txd: got %b want 1", txd); end
        if (bm_req !== 1'b0) begin errs++; $display("FAIL rst_req: got %b want 0", bm_req); end
        if (bm_cyc !== 1'b0) begin errs++; $display("FAIL rst_cyc: got %b want 0", bm_cyc); end
        if (bm_rw !== 1'b1) begin errs++; $display("FAIL rst_rw: got %b want 1", bm_rw); end
        if (bm_ad !== 16'h0000) begin errs++; $display("FAIL rst_ad: got %h want 0000", bm_ad); end
        if (bm_do !== 8'h00) begin errs++; $display("FAIL rst_do: got %h want 00", bm_do); end
        m_do = 8'h00;
        b_reset = 1'b1;
        repeat (2 * DIV) @(negedge clk_in);
    endtask

    task automatic run_frame(input string nm, input logic [7:0] op,
                             input logic [15:0] a, input logic [7:0] d);
        bit is_bus;
        bus_t eb;
        logic [7:0] rep, got;
        bus_q.delete();
        ref_frame(op, a, d, rd_data, is_bus, eb, rep);
        send_frame(op, a, d);
        get_reply(got);
        vectors += 2;
        if (got !== rep) begin
            errs++;
            $display("FAIL %s reply: got %h want %h", nm, got, rep);
        end
        if (bus_q.size() != (is_bus ? 1 : 0)) begin
            errs++;
            $display("FAIL %s ncyc: got %0d want %0d", nm, bus_q.size(), is_bus);
        end else if (is_bus) begin
            vectors++;
            if (bus_q[0] !== eb) begin
                errs++;
                $display("FAIL %s bus: got %h want %h", nm, bus_q[0], eb);
            end
        end
    endtask

    task automatic test_write();
        run_frame("write", 8'h57, 16'h1234, 8'hA5);
    endtask

    task automatic test_read();
        rd_data = 8'h8E;
        run_frame("read", 8'h52, 16'hF000, 8'h00);
    endtask

    task automatic test_bad_opcode();
        run_frame("badop", 8'h41, 16'h0000, 8'h00);
        rd_data = 8'h6C;
        run_frame("after_badop", 8'h52, 16'h0010, 8'h00);
    endtask

    task automatic test_framing();
        send_byte(8'h52, 1'b0);
        repeat (DIV) @(negedge clk_in);
        rd_data = 8'hC3;
        run_frame("framing", 8'h52, 16'h0000, 8'h00);
    endtask

    task automatic test_glitch();
        rxd = 1'b0;
        repeat (3) @(negedge clk_in);
        rxd = 1'b1;
        repeat (2 * DIV) @(negedge clk_in);
        run_frame("glitch", 8'h57, 16'h0F0F, 8'h33);
    endtask

    task automatic test_drop();
        logic [7:0] got;
        bus_q.delete();
        gnt_en  = 0;
        rd_data = 8'h5D;
        send_frame(8'h52, 16'h1111, 8'h00);
        send_byte(8'h41, 1'b1);
        gnt_en = 1;
        get_reply(got);
        repeat (12 * DIV) @(negedge clk_in);
        vectors += 3;
        if (got !== 8'h5D) begin errs++; $display("FAIL drop reply: got %h want 5d", got); end
        if (tx_q.size() != 0) begin errs++; $display("FAIL drop extra: got %0d want 0", tx_q.size()); end
        if (bus_q.size() != 1) begin errs++; $display("FAIL drop ncyc: got %0d want 1", bus_q.size()); end
        tx_q.delete();
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        ack_en = 0;
        send_frame(8'h57, 16'h4321, 8'h77);
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk_in);
            seen = bm_cyc;
        end
        vectors++;
        if (!seen) begin errs++; $display("FAIL rmid_cyc: got 0 want 1"); end
        #2 b_reset = 1'b0;
        #1;
        vectors += 3;
        if (bm_cyc !== 1'b0) begin errs++; $display("FAIL rmid_cyc_drop: got %b want 0", bm_cyc); end
        if (bm_req !== 1'b0) begin errs++; $display("FAIL rmid_req_drop: got %b want 0", bm_req); end
        if (txd !== 1'b1) begin errs++; $display("FAIL rmid_txd: got %b want 1", txd); end
        repeat (3) @(negedge clk_in);
        b_reset = 1'b1;
        ack_en  = 1;
        m_do    = 8'h00;
        repeat (20 * DIV) @(negedge clk_in);
        vectors++;
        if (tx_q.size() != 0) begin errs++; $display("FAIL rmid_noreply: got %0d want 0", tx_q.size()); end
        tx_q.delete();
        run_frame("after_rst", 8'h57, 16'hABCD, 8'h5A);
    endtask

`ifdef BM_ACKTO_EN
    task automatic test_timeout();
        logic [7:0] got;
        bus_q.delete();
        ack_en = 0;
        send_frame(8'h52, 16'h2222, 8'h00);
        get_reply(got);
        ack_en = 1;
        vectors += 3;
        if (got !== 8'h21) begin errs++; $display("FAIL to_reply: got %h want 21", got); end
        if (req_len != TO) begin errs++; $display("FAIL to_len: got %0d want %0d", req_len, TO); end
        if (bus_q.size() != 1) begin errs++; $display("FAIL to_ncyc: got %0d want 1", bus_q.size()); end
    endtask
`endif

    task automatic test_random();
        logic [7:0] op;
        for (int n = 0; n < 16; n++) begin
            int k = $urandom_range(0, 9);
            if (k < 4) op = 8'h52;
            else if (k < 8) op = 8'h57;
            else begin
                op = 8'($urandom);
                while (op == 8'h52 || op == 8'h57) op = 8'($urandom);
            end
            rd_data  = 8'($urandom);
            ack_dly  = $urandom_range(1, 5);
            gnt_drop = $urandom_range(0, 1) == 1;
            run_frame("random", op, 16'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 1) * $urandom_range(0, 2 * DIV)) @(negedge clk_in);
        end
        gnt_drop = 0;
        ack_dly  = 3;
        vectors++;
        if (stab_err != 0) begin errs++; $display("FAIL bus_stable: got %0d changes want 0", stab_err); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad_opcode();
        test_framing();
        test_glitch();
        test_drop();
        test_reset_mid();
`ifdef BM_ACKTO_EN
        test_timeout();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
